// File: rtl/flexka_cmd_issuer_if.sv
// flexka_cmd_issuer_if: job request, operand stream and CommandDataPort bundle for the issuer.
interface flexka_cmd_issuer_if #(
    parameter int FSIZE         = 64,
    parameter int COMMAND_WIDTH = 8
);
    logic                     start;
    logic                     abort;
    logic [15:0]              size_a;
    logic [15:0]              size_b;
    logic [31:0]              out_addr;
    logic                     opnd_valid;
    logic                     opnd_ready;
    logic [FSIZE-1:0]         opnd_data;
    logic                     cmd_valid;
    logic [COMMAND_WIDTH-1:0] cmd_command;
    logic [FSIZE-1:0]         cmd_data0;
    logic [FSIZE-1:0]         cmd_data1;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output start, abort, size_a, size_b, out_addr, opnd_valid, opnd_data,
        input  opnd_ready, cmd_valid, cmd_command, cmd_data0, cmd_data1, busy, done, err
    );

    modport slave (
        input  start, abort, size_a, size_b, out_addr, opnd_valid, opnd_data,
        output opnd_ready, cmd_valid, cmd_command, cmd_data0, cmd_data1, busy, done, err
    );
endinterface

// File: rtl/flexka_cmd_issuer.sv
// flexka_cmd_issuer: turns a multiply job into RESET/SIZE/OUTADDR/DATA/KARATSUBA command beats,
// streaming operand words from a valid/ready port with one registered beat per cycle.
module flexka_cmd_issuer #(
    parameter int FSIZE         = 64,
    parameter int COMMAND_WIDTH = 8,
    parameter int MAX_WORDS     = 10240
) (
    input  logic               clk,
    input  logic               rstn,
    flexka_cmd_issuer_if.slave bus
);
    typedef enum logic [3:0] {IDLE, RST, SZA, SZB, OADDR, DATA_A, DATA_B, KICK, FIN} state_t;

    localparam logic [COMMAND_WIDTH-1:0] OP_RESET  = COMMAND_WIDTH'(1);
    localparam logic [COMMAND_WIDTH-1:0] OP_SIZE_A = COMMAND_WIDTH'(2);
    localparam logic [COMMAND_WIDTH-1:0] OP_SIZE_B = COMMAND_WIDTH'(3);
    localparam logic [COMMAND_WIDTH-1:0] OP_DATA_A = COMMAND_WIDTH'(4);
    localparam logic [COMMAND_WIDTH-1:0] OP_DATA_B = COMMAND_WIDTH'(5);
    localparam logic [COMMAND_WIDTH-1:0] OP_KARA   = COMMAND_WIDTH'(6);
    localparam logic [COMMAND_WIDTH-1:0] OP_OADDR  = COMMAND_WIDTH'(7);
    localparam logic [16:0]              MAXW      = 17'(MAX_WORDS);

    state_t                   r_state;
    logic [15:0]              r_size_a;
    logic [15:0]              r_size_b;
    logic [15:0]              r_idx;
    logic [31:0]              r_out_addr;
    logic                     r_cmd_valid;
    logic [COMMAND_WIDTH-1:0] r_cmd;
    logic [FSIZE-1:0]         r_data0;
    logic [FSIZE-1:0]         r_data1;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic                     w_in_data;
    logic                     w_abort;
    logic                     w_ready;
    logic                     w_hs;
    logic                     w_last;
    logic                     w_size_ok;

    assign w_in_data = r_state == DATA_A || r_state == DATA_B;
    assign w_abort   = bus.abort && r_state != IDLE;
    // abort drops ready at once so a word offered in the abort cycle is never consumed
    assign w_ready   = rstn && w_in_data && !bus.abort;
    assign w_hs      = w_ready && bus.opnd_valid;
    assign w_last    = r_idx == (r_state == DATA_A ? r_size_a : r_size_b) - 16'd1;
    assign w_size_ok = bus.size_a != 16'd0 && bus.size_b != 16'd0 &&
                       {1'b0, bus.size_a} <= MAXW && {1'b0, bus.size_b} <= MAXW;

    assign bus.opnd_ready  = w_ready;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_command = r_cmd;
    assign bus.cmd_data0   = r_data0;
    assign bus.cmd_data1   = r_data1;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;

    // RST/SZA/SZB name the preamble beat on the port; OUTADDR launches while leaving SZB so
    // operands are accepted from the fourth cycle, which leaves OADDR without a cycle of its own
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_size_a    <= '0;
            r_size_b    <= '0;
            r_idx       <= '0;
            r_out_addr  <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= '0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            if (w_abort) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_idx       <= '0;
                r_cmd_valid <= 1'b1;
                r_cmd       <= OP_RESET;
                r_data0     <= '0;
                r_data1     <= '0;
            end else begin
                case (r_state)
                    IDLE: if (bus.start) begin
                        if (w_size_ok) begin
                            r_state     <= RST;
                            r_busy      <= 1'b1;
                            r_size_a    <= bus.size_a;
                            r_size_b    <= bus.size_b;
                            r_out_addr  <= bus.out_addr;
                            r_idx       <= '0;
                            r_cmd_valid <= 1'b1;
                            r_cmd       <= OP_RESET;
                            r_data0     <= '0;
                            r_data1     <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    RST: begin
                        r_state     <= SZA;
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= OP_SIZE_A;
                        r_data0     <= FSIZE'(r_size_a);
                        r_data1     <= '0;
                    end
                    SZA: begin
                        r_state     <= SZB;
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= OP_SIZE_B;
                        r_data0     <= FSIZE'(r_size_b);
                        r_data1     <= '0;
                    end
                    SZB, OADDR: begin
                        r_state     <= DATA_A;
                        r_idx       <= '0;
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= OP_OADDR;
                        r_data0     <= FSIZE'(r_out_addr);
                        r_data1     <= '0;
                    end
                    DATA_A, DATA_B: if (w_hs) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= r_state == DATA_A ? OP_DATA_A : OP_DATA_B;
                        r_data0     <= FSIZE'(r_idx);
                        r_data1     <= bus.opnd_data;
                        r_idx       <= w_last ? '0 : r_idx + 16'd1;
                        if (w_last) r_state <= r_state == DATA_A ? DATA_B : KICK;
                    end
                    KICK: begin
                        r_state     <= FIN;
                        r_cmd_valid <= 1'b1;
                        r_cmd       <= OP_KARA;
                        r_data0     <= '0;
                        r_data1     <= '0;
                    end
                    FIN: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
